// File: rtl/uart_rx_sniffer.sv
// uart_rx_sniffer: 8N1 UART receiver with runtime bit period, feeding a show-ahead FIFO
// drained by a valid/ready consumer.
module uart_rx_sniffer #(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en_i,
    input  logic [DIV_W-1:0]            div_i,
    input  logic                        rxd_i,
    output logic [7:0]                  data_o,
    output logic                        valid_o,
    input  logic                        ready_i,
    output logic [$clog2(FIFO_DEPTH):0] count_o,
    output logic                        frame_err_o,
    output logic                        overflow_o,
    output logic                        busy_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;

    logic [1:0]       state;
    logic             s1, rxs, prev;
    logic [DIV_W-1:0] cnt, d_lat, d;
    logic [2:0]       idx;
    logic [7:0]       sh;
    logic [7:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             tick, fall, push, pop, full, wr;

    always_comb begin
        d    = (div_i < DIV_W'(3)) ? DIV_W'(3) : div_i;
        tick = cnt == '0;
        fall = prev & ~rxs;
        push = en_i && state == STOP && tick && rxs;
        pop  = valid_o & ready_i;
        full = count_o == (AW+1)'(FIFO_DEPTH);
        wr   = push & (~full | pop);
    end

    assign valid_o = count_o != '0;
    assign busy_o  = state != IDLE;
    assign data_o  = valid_o ? mem[rp] : 8'd0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {s1, rxs, prev} <= 3'b111;
            state           <= IDLE;
            cnt             <= '0;
            d_lat           <= '0;
            idx             <= '0;
            sh              <= '0;
            frame_err_o     <= 1'b0;
        end else begin
            s1          <= rxd_i;
            rxs         <= s1;
            prev        <= rxs;
            frame_err_o <= en_i && state == STOP && tick && !rxs;
            // Reload on every sample; the IDLE branch overrides with the half-bit start delay
            cnt         <= tick ? d_lat : cnt - DIV_W'(1);
            if (!en_i) state <= IDLE;
            else begin
                case (state)
                    IDLE: if (fall) begin
                        state <= START;
                        cnt   <= d >> 1;
                        d_lat <= d;
                    end
                    START: if (tick) begin
                        state <= rxs ? IDLE : DATA;
                        idx   <= '0;
                    end
                    DATA: if (tick) begin
                        sh  <= {rxs, sh[7:1]};
                        idx <= idx + 3'd1;
                        if (idx == 3'd7) state <= STOP;
                    end
                    default: if (tick) state <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) if (wr) mem[wp] <= sh;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp         <= '0;
            rp         <= '0;
            count_o    <= '0;
            overflow_o <= 1'b0;
        end else begin
            overflow_o <= push & full & ~pop;
            wp         <= wp + AW'(wr);
            rp         <= rp + AW'(pop);
            count_o    <= count_o + (AW+1)'(wr) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_uart_rx_sniffer.sv
// tb_uart_rx_sniffer: scoreboard bench for uart_rx_sniffer; bytes queued at send, checked on pop.
module tb_uart_rx_sniffer;
    logic        clk = 1'b0, rst_n, en = 1'b1, rxd = 1'b1, ready = 1'b0;
    logic [15:0] div = 16'd15;
    logic [7:0]  data_o;
    logic [3:0]  count_o;
    logic        valid_o, frame_err_o, overflow_o, busy_o;

    uart_rx_sniffer #(.DIV_W(16), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .en_i(en), .div_i(div), .rxd_i(rxd),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready), .count_o(count_o),
        .frame_err_o(frame_err_o), .overflow_o(overflow_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int         cyc = 0, start_cyc = 0, rise_cyc = 0;
    int         n_chk = 0, n_pass = 0, ferr_n = 0, ovf_n = 0, val_n = 0;
    logic       vprev = 1'b0;
    logic [7:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid_o && ready) begin
            if (exp_q.size() == 0) check("pop_unexpected", 32'(data_o), 32'h100);
            else check("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
        end
        if (frame_err_o) ferr_n++;
        if (overflow_o) ovf_n++;
        if (valid_o) val_n++;
        if (valid_o && !vprev) rise_cyc = cyc;
        vprev = valid_o;
    end

    task automatic send(input logic [7:0] b, input logic stop, input int p, input logic keep);
        @(posedge clk); #1;
        start_cyc = cyc;
        if (keep) exp_q.push_back(b);
        rxd = 1'b0;
        repeat (p) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (p) @(posedge clk); #1;
        end
        rxd = stop;
        repeat (p) @(posedge clk); #1;
        rxd = 1'b1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_data"}, 32'(data_o), 0);
        check({tag, "_valid"}, 32'(valid_o), 0);
        check({tag, "_count"}, 32'(count_o), 0);
        check({tag, "_ferr"}, 32'(frame_err_o), 0);
        check({tag, "_ovf"}, 32'(overflow_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    initial begin
        int bc;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk); #1;
        check_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // single byte, latency = sync(2) + edge(1) + half bit + 9 bits + 1
        ready = 1'b1;
        val_n = 0;
        send(8'h55, 1'b1, 16, 1'b1);
        repeat (20) @(posedge clk); #1;
        check("t1_valid_cycles", val_n, 1);
        check("t1_latency", rise_cyc - start_cyc, 155);
        check("t1_ferr", ferr_n, 0);
        check("t1_ovf", ovf_n, 0);
        check("t1_drained", exp_q.size(), 0);

        ready = 1'b0;
        send(8'hA5, 1'b1, 16, 1'b1);
        send(8'h00, 1'b1, 16, 1'b1);
        send(8'hFF, 1'b1, 16, 1'b1);
        repeat (20) @(posedge clk); #1;
        check("t2_count3", 32'(count_o), 3);
        ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t2_count0", 32'(count_o), 0);
        check("t2_drained", exp_q.size(), 0);

        send(8'h3C, 1'b0, 16, 1'b0);
        repeat (20) @(posedge clk); #1;
        check("t3_ferr", ferr_n, 1);
        check("t3_count", 32'(count_o), 0);
        send(8'h81, 1'b1, 16, 1'b1);
        repeat (20) @(posedge clk); #1;
        check("t3_drained", exp_q.size(), 0);
        check("t3_ferr_after", ferr_n, 1);

        @(posedge clk); #1 rxd = 1'b0;
        repeat (3) @(posedge clk); #1 rxd = 1'b1;
        bc = 0;
        repeat (20) begin
            @(negedge clk);
            if (busy_o) bc++;
        end
        check("t4_busy_cycles", bc, 8);
        check("t4_count", 32'(count_o), 0);
        check("t4_ferr", ferr_n, 1);

        ready = 1'b0;
        for (int i = 1; i <= 9; i++) send(8'(i), 1'b1, 16, i <= 8);
        repeat (20) @(posedge clk); #1;
        check("t5_ovf", ovf_n, 1);
        check("t5_count", 32'(count_o), 8);
        ready = 1'b1;
        repeat (15) @(posedge clk); #1;
        check("t5_count0", 32'(count_o), 0);
        check("t5_drained", exp_q.size(), 0);

        fork
            send(8'h6E, 1'b1, 16, 1'b0);
            begin
                repeat (80) @(posedge clk);
                @(negedge clk) check("t6_busy_before", 32'(busy_o), 1);
                @(posedge clk); #1 en = 1'b0;
                @(posedge clk);
                @(negedge clk) check("t6_busy_after", 32'(busy_o), 0);
            end
        join
        en = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t6_count", 32'(count_o), 0);
        check("t6_busy_idle", 32'(busy_o), 0);
        check("t6_ferr", ferr_n, 1);

        ready = 1'b0;
        send(8'h5A, 1'b1, 16, 1'b1);
        repeat (5) @(posedge clk); #1;
        check("t6r_count1", 32'(count_o), 1);
        fork
            send(8'h6E, 1'b1, 16, 1'b0);
            begin
                repeat (80) @(posedge clk);
                #2 rst_n = 1'b0;
                #1 check_zero("t6r_midframe");
                exp_q.delete();
            end
        join
        rst_n = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("t6r_count_after", 32'(count_o), 0);

        div = 16'd1;
        ready = 1'b1;
        send(8'hC3, 1'b1, 4, 1'b1);
        repeat (10) @(posedge clk); #1;
        check("t7_latency", rise_cyc - start_cyc, 41);
        check("t7_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
